uart_responder: RTL and testbench
=================================

# uart_responder

Byte-wide serial port peripheral that sits on the far side of the memory controller's shared RAM1 data bus and answers its serial-port strobes. It responds to `rdn` and `wrn` on `data[7:0]` and reports the status flags `data_ready`, `tbre` and `tsre`, which the controller reads at 0xBF01. It serializes written bytes onto `txd` and deserializes `rxd` into a receive buffer. It is used as the on-FPGA stand-in for the board UART chip, in simulation and in builds without the external part.

## Interface
- `CLKS_PER_BIT`, default 16: CLK cycles per serial bit; must be even and ≥ 4.
- `CLK` input 1: single clock. All logic is on its rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `rdn` input 1: read strobe, active-low, synchronous to `CLK`.
- `wrn` input 1: write strobe, active-low, synchronous to `CLK`.
- `data` inout 8: bus low byte. Driven only while `rdn`=0, otherwise high-Z.
- `data_ready` output 1: receive buffer (RBR) holds an unread byte.
- `tbre` output 1: transmit holding register (THR) is empty.
- `tsre` output 1: transmit shift register is empty and the line is idle.
- `txd` output 1: serial out. Idle high; frame is 8N1, LSB first.
- `rxd` input 1: serial in, asynchronous, 8N1.

## Operation
- **Reset values** (applied asynchronously): `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data`=Z, THR=RBR=0, TX FSM=IDLE, RX FSM=IDLE, all counters 0.
- **Strobe edge detection:** `rdn_q` and `wrn_q` are registered copies of the strobes.
  - Write edge: `wrn_q`=1 and `wrn`=0.
  - Read release: `rdn_q`=0 and `rdn`=1.
- **Write:**
  - On a write edge with `tbre`=1: THR ← `data`, `tbre` ← 0.
  - A write edge while `tbre`=0 is ignored. THR is unchanged and no flag changes.
- **TX FSM** (IDLE, START, DATA, STOP):
  - IDLE with THR full: shifter ← THR, `tbre` ← 1, `tsre` ← 0, `txd` ← 0, go to START.
  - Each of START, DATA and STOP holds for `CLKS_PER_BIT` cycles per bit. DATA sends bits 0..7 in order. STOP drives `txd`=1.
  - At the end of STOP, if THR is full, load the next byte directly into START with no idle gap; `tsre` stays 0. Otherwise set `tsre` ← 1 and go to IDLE.
- **Read:**
  - While `rdn`=0: `data` = RBR.
  - On a read release: `data_ready` ← 0.
- **RX FSM** (IDLE, START, DATA, STOP):
  - `rxd` passes through a 2-flop synchronizer, giving `rxs`.
  - IDLE → START on `rxs`=0.
  - At `CLKS_PER_BIT/2` cycles into START, recheck `rxs`. If it is 1, treat it as a false start and return to IDLE.
  - Sample data bits every `CLKS_PER_BIT` cycles thereafter, LSB first, then sample the stop bit.
  - Stop bit = 1: RBR ← shifted byte, `data_ready` ← 1. This overwrites an unread byte; no overrun flag is kept.
  - Stop bit = 0: framing error. Discard the byte, leave `data_ready` unchanged, and stay in STOP until `rxs`=1, then go to IDLE.
- **Simultaneous events:**
  - RX completion in the same cycle as a read release: set wins, so `data_ready`=1 with the new byte.
  - A write edge in the same cycle that the TX FSM unloads THR is impossible, because a write is accepted only when `tbre`=1.
- **Reset mid-frame:** the frame is aborted, `txd` returns high immediately, and any partial RX byte is lost.

## Timing
- **Transmit**, with E0 the edge that sees the write edge:
  - E0: `tbre` falls.
  - E0+1: `tbre` rises, `tsre` falls, `txd` falls (start bit).
  - Bit k (start = 0, stop = 9) occupies edges E0+1+k·N to E0+1+(k+1)·N, where N = `CLKS_PER_BIT`.
  - E0+1+10N: `tsre` rises if THR is empty.
- **Receive**, with R0 the first edge where `rxs`=0:
  - Start recheck at R0+N/2.
  - Data bit i sampled at R0+N/2+(i+1)·N.
  - Stop bit sampled at R0+N/2+9N; `data_ready` rises on that same edge.
- **Read path:** bus drive follows `rdn` combinationally. `data_ready` falls one edge after `rdn` returns high.
- **Latency:** `rxd`→`rxs` is 2 cycles.

## Test plan
- **Reset:** assert `RST` mid-frame → `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data`=Z, with no clock edge required.
- **Single transmit:** write 0xA5 with N=16 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, 16 cycles each; `tbre` low for exactly 1 cycle; `tsre` high 161 cycles after E0.
- **Back-to-back transmit:** write 0x55, then 0x0F once `tbre`=1 → two frames with no idle bit between them; a third write while `tbre`=0 is dropped; `tsre` rises once after 320 cycles.
- **Receive and read:** drive an 8N1 frame of 0x3C on `rxd` → `data_ready`=1 at R0+152; pulse `rdn` low → `data`=0x3C while low; `data_ready`=0 one edge after release.
- **Receive errors:** an `rxd` low glitch of 4 cycles → no byte (false start). A frame of 0x81 with stop bit 0 → RBR and `data_ready` unchanged, and the receiver recovers on the next valid frame.
- **Simultaneous set/clear:** release `rdn` on the same edge the stop bit of 0x77 is sampled → `data_ready` stays 1 and RBR=0x77.

Source files
------------

// File: rtl/uart_responder.sv
// Byte-wide UART stand-in for the memory controller's RAM1 bus: 8N1 transmit and receive
// with a one-byte holding register on each side and status flags for the 0xBF01 poll.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// TX_IDLE   | line high, waiting for THR to fill
// TX_START  | driving start bit (0)
// TX_DATA   | shifting out bits 0..7, LSB first
// TX_STOP   | driving stop bit (1); chains the next byte if THR is full
// RX_IDLE   | waiting for rxs to go low
// RX_START  | half-bit wait, then recheck for a false start
// RX_DATA   | sampling bits 0..7 at bit centres
// RX_STOP   | sampling stop bit; on framing error waits for line high

module uart_responder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] data,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    tx_state_t     tx_state;
    logic [7:0]    thr;
    logic [7:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic          wrn_q;

    rx_state_t     rx_state;
    logic [7:0]    rbr;
    logic [7:0]    rx_shift;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic          rx_err;
    logic          rx_meta;
    logic          rxs;
    logic          rdn_q;

    logic wr_edge;
    logic rd_release;

    assign wr_edge    = wrn_q & ~wrn;
    assign rd_release = ~rdn_q & rdn;
    assign data       = rdn ? 8'bz : rbr;

    // THR is full whenever tbre is low, so the write accept and the FSM unload never collide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrn_q    <= 1'b1;
            thr      <= 8'h00;
            tx_shift <= 8'h00;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_state <= TX_IDLE;
            tbre     <= 1'b1;
            tsre     <= 1'b1;
            txd      <= 1'b1;
        end else begin
            wrn_q <= wrn;
            if (wr_edge && tbre) begin
                thr  <= data;
                tbre <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (!tbre) begin
                        tx_shift <= thr;
                        tbre     <= 1'b1;
                        tsre     <= 1'b0;
                        txd      <= 1'b0;
                        tx_cnt   <= BIT_TC;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= 3'd0;
                        tx_cnt   <= BIT_TC;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_TC;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (!tbre) begin
                            tx_shift <= thr;
                            tbre     <= 1'b1;
                            txd      <= 1'b0;
                            tx_cnt   <= BIT_TC;
                            tx_state <= TX_START;
                        end else begin
                            tsre     <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // data_ready clear is written first so a same-cycle completion overrides it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rdn_q      <= 1'b1;
            rbr        <= 8'h00;
            rx_shift   <= 8'h00;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_err     <= 1'b0;
            rx_state   <= RX_IDLE;
            data_ready <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rdn_q   <= rdn;
            if (rd_release) begin
                data_ready <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_cnt   <= HALF_TC;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rxs) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= BIT_TC;
                            rx_bit   <= 3'd0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rxs, rx_shift[7:1]};
                        rx_cnt   <= BIT_TC;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_err) begin
                        if (rxs) begin
                            rx_err   <= 1'b0;
                            rx_state <= RX_IDLE;
                        end
                    end else if (rx_cnt == '0) begin
                        if (rxs) begin
                            rbr        <= rx_shift;
                            data_ready <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder: transmit framing, chaining, receive, errors,
// read/complete collision and asynchronous reset, all against hand-derived values.

module tb_uart_responder;

    localparam int N = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_data = 8'h00;
    wire  [7:0] data;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       txd;

    int n_tests = 0;
    int n_fail  = 0;

    assign data = tb_drv ? tb_data : 8'bz;

    uart_responder #(.CLKS_PER_BIT(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rdn        (rdn),
        .wrn        (wrn),
        .data       (data),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .txd        (txd),
        .rxd        (rxd)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ends just after the edge that sees the write edge (E0).
    task automatic write_byte(input logic [7:0] b);
        tb_data = b;
        tb_drv  = 1'b1;
        wrn     = 1'b0;
        tick();
        wrn    = 1'b1;
        tb_drv = 1'b0;
    endtask

    // Called just after the edge that starts the start bit, skip cycles late;
    // returns just after the last edge of the stop bit's final cycle.
    task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = skip; i < 10 * N; i++) begin
            check(tag, txd, fr[i / N]);
            if (i != 10 * N - 1) tick();
        end
    endtask

    // Drives start bit and 8 data bits, N cycles each; returns at the stop-bit boundary.
    task automatic rx_drive(input logic [7:0] b);
        logic [8:0] fr;
        fr = {b, 1'b0};
        for (int k = 0; k < 9; k++) begin
            rxd = fr[k];
            ticks(N);
        end
    endtask

    task automatic read_check(input logic [7:0] exp, input string tag);
        rdn = 1'b0;
        #1;
        check({tag, "_data"}, data, exp);
        tick();
        check({tag, "_rdy_held"}, data_ready, 1'b1);
        rdn     = 1'b1;
        tb_drv  = 1'b1;
        tb_data = 8'h00;
        #1;
        check({tag, "_bus_free"}, data, 8'h00);
        tb_drv = 1'b0;
        tick();
        check({tag, "_rdy_clr"}, data_ready, 1'b0);
    endtask

    initial begin
        #2 RST = 1'b1;
        #2;
        tb_drv  = 1'b1;
        tb_data = 8'h00;
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_tbre", tbre, 1'b1);
        check("rst_tsre", tsre, 1'b1);
        check("rst_rdy", data_ready, 1'b0);
        check("rst_bus", data, 8'h00);
        tb_drv = 1'b0;
        ticks(3);
        RST = 1'b0;
        ticks(3);

        // Single transmit of 0xA5
        write_byte(8'hA5);
        check("a5_tbre_e0", tbre, 1'b0);
        tick();
        check("a5_tbre_e1", tbre, 1'b1);
        check("a5_tsre_e1", tsre, 1'b0);
        check_frame(8'hA5, 0, "a5_txd");
        check("a5_tsre_e160", tsre, 1'b0);
        tick();
        check("a5_tsre_e161", tsre, 1'b1);
        check("a5_txd_idle", txd, 1'b1);
        ticks(5);

        // Back-to-back 0x55, 0x0F with a dropped third write
        write_byte(8'h55);
        tick();
        check("b2b_tbre_s", tbre, 1'b1);
        write_byte(8'h0F);
        check("b2b_tbre_w2", tbre, 1'b0);
        tick();
        write_byte(8'hEE);
        check("b2b_tbre_w3", tbre, 1'b0);
        tick();
        check_frame(8'h55, 4, "b2b_txd_55");
        tick();
        check("b2b_tbre_2nd", tbre, 1'b1);
        check("b2b_tsre_2nd", tsre, 1'b0);
        check_frame(8'h0F, 0, "b2b_txd_0f");
        check("b2b_tsre_e320", tsre, 1'b0);
        tick();
        check("b2b_tsre_e321", tsre, 1'b1);
        ticks(3 * N);
        check("b2b_no_third", txd, 1'b1);
        check("b2b_tsre_idle", tsre, 1'b1);

        // Receive 0x3C; data_ready at R0+152 = e+155
        tick();
        rx_drive(8'h3C);
        rxd = 1'b1;
        ticks(10);
        check("rx3c_rdy_pre", data_ready, 1'b0);
        tick();
        check("rx3c_rdy", data_ready, 1'b1);
        ticks(10);

        // False start glitch leaves data_ready and RBR alone
        rxd = 1'b0;
        ticks(4);
        rxd = 1'b1;
        ticks(200);
        check("glitch_rdy", data_ready, 1'b1);

        // Framing error on 0x81 discards the byte
        rx_drive(8'h81);
        rxd = 1'b0;
        ticks(2 * N);
        rxd = 1'b1;
        ticks(2 * N);
        check("frm_rdy", data_ready, 1'b1);
        read_check(8'h3C, "rd3c");

        // 0x77 completes on the same edge as a read release
        ticks(5);
        rx_drive(8'h77);
        rxd = 1'b1;
        ticks(5);
        rdn = 1'b0;
        ticks(5);
        check("sim_rdy_pre", data_ready, 1'b0);
        rdn = 1'b1;
        tick();
        check("sim_rdy_set", data_ready, 1'b1);
        ticks(5);
        read_check(8'h77, "rd77");

        // Reset mid transmit frame with a byte waiting
        ticks(5);
        rx_drive(8'h5A);
        rxd = 1'b1;
        ticks(11);
        check("rst5a_rdy", data_ready, 1'b1);
        write_byte(8'h99);
        ticks(41);
        check("rst_mid_txd", txd, 1'b0);
        check("rst_mid_tsre", tsre, 1'b0);
        RST     = 1'b1;
        tb_drv  = 1'b1;
        tb_data = 8'h00;
        #2;
        check("arst_txd", txd, 1'b1);
        check("arst_tbre", tbre, 1'b1);
        check("arst_tsre", tsre, 1'b1);
        check("arst_rdy", data_ready, 1'b0);
        check("arst_bus", data, 8'h00);
        tb_drv = 1'b0;
        tick();
        RST = 1'b0;
        ticks(3 * N);
        check("post_rst_txd", txd, 1'b1);
        check("post_rst_tsre", tsre, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
